// File: rtl/reduce_frame_module_pkg.sv
// Shared types and helpers for the frame reducer.
// Operator encoding, FSM states and the bit-combine function.
package reduce_pkg;

    typedef enum logic [1:0] {
        MODE_OR   = 2'b00,
        MODE_AND  = 2'b01,
        MODE_XOR  = 2'b10,
        MODE_RSVD = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ACCUM = 2'b01,
        S_HOLD  = 2'b10
    } state_t;

    // Combine two bits with the frame operator; the reserved code acts as OR.
    function automatic logic apply_op(mode_t m, logic a, logic b);
        logic v;
        case (m)
            MODE_AND: v = a & b;
            MODE_XOR: v = a ^ b;
            default:  v = a | b;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/reduce_frame_module_if.sv
// Beat-in / flag-out handshake bundle for the frame reducer.
// master drives beats and consumes results; slave is the reducer.
interface reduce_frame_module_if #(
    parameter int WIDTH_I = 4,
    parameter int CNT_W   = 3
);
    logic [1:0]         mode_i;
    logic               clear_i;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH_I-1:0] in;
    logic               out_valid;
    logic               out_ready;
    logic               out;
    logic [CNT_W-1:0]   beat_cnt;

    modport master (
        output mode_i,
        output clear_i,
        output in_valid,
        output in,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out,
        input  beat_cnt
    );

    modport slave (
        input  mode_i,
        input  clear_i,
        input  in_valid,
        input  in,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out,
        output beat_cnt
    );
endinterface

// File: rtl/reduce_frame_module_op_comb.sv
// Per-beat vector reduction with a selectable operator.
// Generalises the plain OR reducer to OR/AND/XOR.
module reduce_op_comb
    import reduce_pkg::*;
#(
    parameter int WIDTH_I = 4
) (
    input  logic [WIDTH_I-1:0] i_in,
    input  mode_t              i_mode,
    output logic               o_r
);

    // Reduce the whole beat to one bit; reserved code falls back to OR.
    always_comb begin
        o_r = |i_in;
        case (i_mode)
            MODE_AND: o_r = &i_in;
            MODE_XOR: o_r = ^i_in;
            default:  o_r = |i_in;
        endcase
    end

endmodule

// File: rtl/reduce_frame_module.sv
// Frame reducer: folds FRAME_LEN reduced beats into one result bit.
// Valid/ready on both sides; one frame in flight at a time.
module reduce_frame_module
    import reduce_pkg::*;
#(
    parameter  int WIDTH_I   = 4,
    parameter  int FRAME_LEN = 4,
    localparam int CNT_W     = $clog2(FRAME_LEN + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    reduce_frame_module_if.slave  bus
);

    state_t           r_state;
    mode_t            r_op;
    logic             r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;
    logic             r_out_valid;

    state_t           w_state_nxt;
    mode_t            w_op_nxt;
    logic             w_acc_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_out_nxt;
    logic             w_out_valid_nxt;

    mode_t            w_mode_in;
    mode_t            w_op_sel;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_r;
    logic             w_fold;
    logic             w_last;

    assign w_mode_in  = mode_t'(bus.mode_i);
    // A new frame takes the live mode; an open frame keeps its latched op.
    assign w_op_sel   = (r_state == S_IDLE) ? w_mode_in : r_op;
    assign w_in_ready = (r_state != S_HOLD);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_fold     = apply_op(r_op, r_acc, w_r);
    assign w_last     = (r_cnt == CNT_W'(FRAME_LEN - 1));

    reduce_op_comb #(
        .WIDTH_I (WIDTH_I)
    ) u_op (
        .i_in   (bus.in),
        .i_mode (w_op_sel),
        .o_r    (w_r)
    );

    // Next-state and datapath update; clear_i outranks the handshake.
    always_comb begin
        w_state_nxt     = r_state;
        w_op_nxt        = r_op;
        w_acc_nxt       = r_acc;
        w_cnt_nxt       = r_cnt;
        w_out_nxt       = r_out;
        w_out_valid_nxt = r_out_valid;

        if (bus.clear_i) begin
            w_state_nxt     = S_IDLE;
            w_acc_nxt       = 1'b0;
            w_cnt_nxt       = '0;
            w_out_valid_nxt = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        w_op_nxt  = w_mode_in;
                        w_acc_nxt = w_r;
                        w_cnt_nxt = CNT_W'(1);
                        if (FRAME_LEN == 1) begin
                            w_out_nxt       = w_r;
                            w_out_valid_nxt = 1'b1;
                            w_state_nxt     = S_HOLD;
                        end else begin
                            w_state_nxt = S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_accept) begin
                        w_acc_nxt = w_fold;
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                        if (w_last) begin
                            w_out_nxt       = w_fold;
                            w_out_valid_nxt = 1'b1;
                            w_state_nxt     = S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        w_out_valid_nxt = 1'b0;
                        w_cnt_nxt       = '0;
                        w_state_nxt     = S_IDLE;
                    end
                end
                default: begin
                    w_state_nxt     = S_IDLE;
                    w_acc_nxt       = 1'b0;
                    w_cnt_nxt       = '0;
                    w_out_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // State, op latch, accumulator, counter and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op        <= MODE_OR;
            r_acc       <= 1'b0;
            r_cnt       <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_op        <= w_op_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_out       <= w_out_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out       = r_out;
    assign bus.beat_cnt  = r_cnt;

endmodule

// File: tb/tb_reduce_frame_module.sv
// Directed bench for reduce_frame_module: frame vectors,
// backpressure, abort, reset and a FRAME_LEN=1 sweep.
module tb_reduce_frame_module;
    import reduce_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    reduce_frame_module_if #(.WIDTH_I(4), .CNT_W(3)) bus ();
    reduce_frame_module_if #(.WIDTH_I(4), .CNT_W(1)) bus1 ();

    reduce_frame_module #(.WIDTH_I(4), .FRAME_LEN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    reduce_frame_module #(.WIDTH_I(4), .FRAME_LEN(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [15:0] beats;
        bit          flip;
        logic        exp;
    } vec_t;

    vec_t tv [8];
    int   n_chk  = 0;
    int   n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Beat k sits in beats[4k+3:4k]; flip switches mode_i to AND from beat 2.
    task automatic send_frame(input logic [1:0] m, input logic [15:0] b,
                              input bit flip);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in       = b[k*4 +: 4];
            bus.mode_i   = (flip && k >= 2) ? 2'b01 : m;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in       = 4'h0;
    endtask

    task automatic chk_hold(input string name, input logic exp);
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_out"}, 32'(bus.out), 32'(exp));
        chk({name, "_cnt"}, 32'(bus.beat_cnt), 32'd4);
        chk({name, "_rdy"}, 32'(bus.in_ready), 32'd0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
        chk({name, "_rel_cnt"}, 32'(bus.beat_cnt), 32'd0);
        chk({name, "_rel_rdy"}, 32'(bus.in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] v;
        logic       e;

        tv[0] = '{"or_hit",  2'b00, {4'h0, 4'h4, 4'h0, 4'h0}, 1'b0, 1'b1};
        tv[1] = '{"or_zero", 2'b00, 16'h0000,                 1'b0, 1'b0};
        tv[2] = '{"and_miss",2'b01, {4'hF, 4'hE, 4'hF, 4'hF}, 1'b0, 1'b0};
        tv[3] = '{"and_all", 2'b01, 16'hFFFF,                 1'b0, 1'b1};
        tv[4] = '{"rsvd_or", 2'b11, {4'h1, 4'h0, 4'h0, 4'h0}, 1'b0, 1'b1};
        tv[5] = '{"xor_par", 2'b10, {4'hF, 4'h7, 4'h3, 4'h1}, 1'b0, 1'b0};
        tv[6] = '{"xor_one", 2'b10, {4'h0, 4'h0, 4'h0, 4'h1}, 1'b0, 1'b1};
        tv[7] = '{"xor_flip",2'b10, {4'h0, 4'h0, 4'h0, 4'h1}, 1'b1, 1'b1};

        bus.mode_i    = 2'b00;
        bus.clear_i   = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in        = 4'h0;
        bus.out_ready = 1'b1;
        bus1.mode_i    = 2'b00;
        bus1.clear_i   = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in        = 4'h0;
        bus1.out_ready = 1'b1;

        rst = 1'b1;
        #12;
        chk("rst_out", 32'(bus.out), 32'd0);
        chk("rst_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            send_frame(tv[i].m, tv[i].beats, tv[i].flip);
            chk_hold(tv[i].name, tv[i].exp);
            @(negedge clk);
            chk_idle(tv[i].name);
        end

        // Backpressure: result held five cycles, offered beats ignored.
        bus.out_ready = 1'b0;
        send_frame(2'b00, {4'h1, 4'h0, 4'h0, 4'h0}, 1'b0);
        for (int c = 0; c < 5; c++) begin
            chk_hold("bp", 1'b1);
            bus.in_valid = 1'b1;
            bus.in       = 4'hF;
            @(negedge clk);
        end
        chk_hold("bp_end", 1'b1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        chk_idle("bp");
        send_frame(2'b01, {4'hF, 4'hE, 4'hF, 4'hF}, 1'b0);
        chk_hold("bp_next", 1'b0);
        @(negedge clk);
        chk_idle("bp_next");

        // Abort after two beats; out keeps the previous result.
        send_frame(2'b00, {4'h0, 4'h4, 4'h0, 4'h0}, 1'b0);
        chk_hold("pre_clr", 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in       = 4'h1;
        bus.mode_i   = 2'b10;
        @(negedge clk);
        bus.in       = 4'h3;
        @(negedge clk);
        chk("clr_cnt_before", 32'(bus.beat_cnt), 32'd2);
        bus.clear_i  = 1'b1;
        bus.in       = 4'hF;
        @(negedge clk);
        bus.clear_i  = 1'b0;
        bus.in_valid = 1'b0;
        chk("clr_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("clr_valid", 32'(bus.out_valid), 32'd0);
        chk("clr_rdy", 32'(bus.in_ready), 32'd1);
        chk("clr_out_kept", 32'(bus.out), 32'd1);
        send_frame(2'b10, 16'h0000, 1'b0);
        chk_hold("clr_fresh", 1'b0);
        @(negedge clk);
        chk_idle("clr_fresh");

        // Reset mid-frame clears outputs without waiting for a clock edge.
        send_frame(2'b00, {4'h0, 4'h4, 4'h0, 4'h0}, 1'b0);
        chk_hold("pre_rst", 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in       = 4'h2;
        bus.mode_i   = 2'b00;
        @(negedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mrst_out", 32'(bus.out), 32'd0);
        chk("mrst_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_cnt", 32'(bus.beat_cnt), 32'd0);
        chk("mrst_rdy", 32'(bus.in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        send_frame(2'b01, 16'hFFFF, 1'b0);
        chk_hold("mrst_fresh", 1'b1);
        @(negedge clk);
        chk_idle("mrst_fresh");

        // FRAME_LEN=1 sweep against a reduction model.
        for (int m = 0; m < 4; m++) begin
            for (int x = 0; x < 16; x++) begin
                v = 4'(x);
                e = (m == 1) ? &v : (m == 2) ? ^v : |v;
                @(negedge clk);
                bus1.in_valid = 1'b1;
                bus1.in       = v;
                bus1.mode_i   = 2'(m);
                @(negedge clk);
                bus1.in_valid = 1'b0;
                chk($sformatf("sweep_m%0d_v%0d_valid", m, x),
                    32'(bus1.out_valid), 32'd1);
                chk($sformatf("sweep_m%0d_v%0d_out", m, x),
                    32'(bus1.out), 32'(e));
                chk($sformatf("sweep_m%0d_v%0d_cnt", m, x),
                    32'(bus1.beat_cnt), 32'd1);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
